// File: rtl/alu_issue_ctrl.sv
// Issue stage for alu_8bit: queues (opcode, A, B) words, drives them to the ALU one at a time,
// captures the ALU result and offers it downstream on a valid/ready handshake.
module alu_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_opc,
  input  logic [7:0]    in_a,
  input  logic [7:0]    in_b,
  output logic [7:0]    alu_opc,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  input  logic [7:0]    alu_z,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [7:0]    res_z,
  output logic [7:0]    res_opc,
  output logic          busy,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    alu_opc_q, alu_opc_d;
  logic [7:0]    alu_a_q, alu_a_d;
  logic [7:0]    alu_b_q, alu_b_d;
  logic          res_valid_q, res_valid_d;
  logic [7:0]    res_z_q, res_z_d;
  logic [7:0]    res_opc_q, res_opc_d;
  logic [23:0]   mem_q [DEPTH];
  logic [23:0]   mem_d [DEPTH];
  logic [23:0]   head;
  logic          full;
  logic          push;
  logic          pop;

  assign full     = (count_q == CW'(DEPTH));
  assign in_ready = !full && !reset;
  assign push     = in_valid && in_ready;
  assign head     = mem_q[rd_ptr_q];

  // Storage is not reset: occupancy and pointers alone define which entries are live.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      assign mem_d[gi] = (push && (wr_ptr_q == AW'(gi))) ? {in_opc, in_a, in_b} : mem_q[gi];
      always_ff @(posedge clock) begin
        mem_q[gi] <= mem_d[gi];
      end
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    alu_opc_d   = alu_opc_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    res_valid_d = res_valid_q;
    res_z_d     = res_z_q;
    res_opc_d   = res_opc_q;
    case (state_q)
      IDLE: begin
        if (enable && (count_q != '0)) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_z_d     = alu_z;
        res_opc_d   = alu_opc_q;
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (enable && (count_q != '0)) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // ALU inputs move only on a pop so the combinational ALU never sees stray changes.
    if (pop) begin
      {alu_opc_d, alu_a_d, alu_b_d} = head;
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_opc_q   <= 8'h00;
      alu_a_q     <= 8'h00;
      alu_b_q     <= 8'h00;
      res_valid_q <= 1'b0;
      res_z_q     <= 8'h00;
      res_opc_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alu_opc_q   <= alu_opc_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      res_valid_q <= res_valid_d;
      res_z_q     <= res_z_d;
      res_opc_q   <= res_opc_d;
    end
  end

  assign alu_opc   = alu_opc_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign res_valid = res_valid_q;
  assign res_z     = res_z_q;
  assign res_opc   = res_opc_q;
  assign count     = count_q;
  assign busy      = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: stimulus pushes expected {opc, z} on acceptance,
// a monitor pops and compares on every result handshake. A small ALU model closes the loop.
module tb_alu_issue_ctrl;
  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_opc, in_a, in_b;
  logic [7:0] alu_opc, alu_a, alu_b, alu_z;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_z, res_opc;
  logic       busy;
  logic [2:0] count;

  int total = 0;
  int bad = 0;
  int n_results = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];
  int res_cyc[$];

  alu_issue_ctrl #(.DEPTH(4), .CW(3)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opc(in_opc), .in_a(in_a), .in_b(in_b),
    .alu_opc(alu_opc), .alu_a(alu_a), .alu_b(alu_b), .alu_z(alu_z),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_z(res_z), .res_opc(res_opc),
    .busy(busy), .count(count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference ALU: 0x20 add, 0x01 sub, 0x02 mul, 0x03 or, 0x04 and.
  always_comb begin
    alu_z = alu_a ^ alu_b;
    case (alu_opc)
      8'h20: alu_z = alu_a + alu_b;
      8'h01: alu_z = alu_a - alu_b;
      8'h02: alu_z = 8'(alu_a * alu_b);
      8'h03: alu_z = alu_a | alu_b;
      8'h04: alu_z = alu_a & alu_b;
      default: alu_z = alu_a ^ alu_b;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one line per delivered result.
  always @(negedge clock) begin
    if (!reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(res_z), 32'hFFFF_FFFF);
      end else begin
        logic [15:0] item;
        item = exp_q.pop_front();
        check("res_opc", 32'(res_opc), 32'(item[15:8]));
        check("res_z", 32'(res_z), 32'(item[7:0]));
        $display("result #%0d cyc=%0d opc=0x%02h z=0x%02h", n_results, cyc, res_opc, res_z);
      end
      n_results++;
      res_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] o, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] z);
    int waited = 0;
    in_valid = 1'b1;
    in_opc = o;
    in_a = a;
    in_b = b;
    @(negedge clock);
    while (!in_ready && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready) begin
      check("push_timeout", 32'(in_ready), 32'd1);
    end else begin
      exp_q.push_back({o, z});
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    @(negedge clock);
    while ((exp_q.size() != 0 || busy || res_valid) && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    check("drain_done", 32'(exp_q.size() == 0 && !busy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] t6_opc [12] = '{8'h20, 8'h01, 8'h03, 8'h02, 8'h04, 8'h20,
                             8'h01, 8'h03, 8'h02, 8'h04, 8'h20, 8'h01};
  logic [7:0] t6_a   [12] = '{8'h10, 8'h50, 8'hA0, 8'h10, 8'hF0, 8'hFF,
                             8'h00, 8'h11, 8'h07, 8'h0F, 8'h80, 8'h33};
  logic [7:0] t6_b   [12] = '{8'h20, 8'h08, 8'h05, 8'h10, 8'h3C, 8'h02,
                             8'h01, 8'h22, 8'h06, 8'hF5, 8'h80, 8'h11};
  logic [7:0] t6_z   [12] = '{8'h30, 8'h48, 8'hA5, 8'h00, 8'h30, 8'h01,
                             8'hFF, 8'h33, 8'h2A, 8'h05, 8'h00, 8'h22};

  initial begin
    int base;
    reset = 1'b1;
    enable = 1'b1;
    in_valid = 1'b0;
    in_opc = 8'h00;
    in_a = 8'h00;
    in_b = 8'h00;
    res_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("in_ready_in_reset", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_alu", {8'h0, alu_opc, alu_a, alu_b}, 32'd0);
    check("rst_res", {16'h0, res_z, res_opc}, 32'd0);

    // Latency: pop one cycle after acceptance, result two cycles after
    tick();
    push(8'h20, 8'h05, 8'h03, 8'h08);
    @(negedge clock);
    check("lat_count_e0", 32'(count), 32'd1);
    check("lat_no_bypass", 32'(alu_opc), 32'h00);
    @(negedge clock);
    check("lat_alu_e1", {8'h0, alu_opc, alu_a, alu_b}, 32'h00200503);
    check("lat_res_valid_e1", 32'(res_valid), 32'd0);
    @(negedge clock);
    check("lat_res_valid_e2", 32'(res_valid), 32'd1);
    drain();

    // Back-to-back with res_ready high
    tick();
    base = res_cyc.size();
    push(8'h01, 8'h10, 8'h01, 8'h0F);
    push(8'h03, 8'hF0, 8'h0F, 8'hFF);
    push(8'h02, 8'h03, 8'h04, 8'h0C);
    drain();
    check("b2b_count", 32'(res_cyc.size() - base), 32'd3);
    if (res_cyc.size() - base == 3) begin
      check("b2b_gap1", 32'(res_cyc[base+1] - res_cyc[base]), 32'd2);
      check("b2b_gap2", 32'(res_cyc[base+2] - res_cyc[base+1]), 32'd2);
    end

    // Back-pressure fills the FIFO while the first result is held
    tick();
    res_ready = 1'b0;
    push(8'h20, 8'h01, 8'h02, 8'h03);
    check("bp_count1", 32'(count), 32'd1);
    push(8'h01, 8'h09, 8'h04, 8'h05);
    check("bp_pushpop_count", 32'(count), 32'd1);
    check("bp_popped_opc", 32'(alu_opc), 32'h20);
    push(8'h03, 8'h0C, 8'h30, 8'h3C);
    push(8'h02, 8'h05, 8'h05, 8'h19);
    push(8'h04, 8'hFF, 8'h3C, 8'h3C);
    check("bp_count_full", 32'(count), 32'd4);
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    check("bp_held_valid", 32'(res_valid), 32'd1);
    check("bp_held_z", 32'(res_z), 32'h03);
    res_ready = 1'b1;
    @(negedge clock);
    check("bp_in_ready_before_pop", 32'(in_ready), 32'd0);
    @(negedge clock);
    check("bp_in_ready_after_pop", 32'(in_ready), 32'd1);
    check("bp_count_after_pop", 32'(count), 32'd3);
    drain();
    check("bp_count_empty", 32'(count), 32'd0);

    // Enable gating
    tick();
    enable = 1'b0;
    push(8'h20, 8'h40, 8'h02, 8'h42);
    push(8'h01, 8'h07, 8'h07, 8'h00);
    repeat (3) @(negedge clock);
    check("en_count_gated", 32'(count), 32'd2);
    check("en_alu_hold", 32'(alu_opc), 32'h04);
    check("en_no_result", 32'(res_valid), 32'd0);
    tick();
    enable = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("en_pop_opc", 32'(alu_opc), 32'h20);
    check("en_pop_count", 32'(count), 32'd1);
    enable = 1'b0;
    repeat (4) @(negedge clock);
    check("en_inflight_done", 32'(exp_q.size()), 32'd1);
    check("en_count_hold", 32'(count), 32'd1);
    check("en_alu_stable", {8'h0, alu_opc, alu_a, alu_b}, 32'h00204002);
    tick();
    enable = 1'b1;
    drain();

    // Reset mid-operation drops everything
    tick();
    enable = 1'b0;
    push(8'h20, 8'h01, 8'h01, 8'h02);
    push(8'h01, 8'h05, 8'h01, 8'h04);
    push(8'h03, 8'h01, 8'h02, 8'h03);
    push(8'h04, 8'h0F, 8'h03, 8'h03);
    tick();
    enable = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("rmo_exec_opc", 32'(alu_opc), 32'h20);
    check("rmo_count_before", 32'(count), 32'd3);
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("rmo_res_valid", 32'(res_valid), 32'd0);
    check("rmo_count", 32'(count), 32'd0);
    check("rmo_busy", 32'(busy), 32'd0);
    check("rmo_alu_opc", 32'(alu_opc), 32'h00);
    tick();
    push(8'h04, 8'hAA, 8'h0F, 8'h0A);
    drain();

    // Pointer wrap over 12 words, starting from a full FIFO
    tick();
    res_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 5) res_ready = 1'b1;
      push(t6_opc[i], t6_a[i], t6_b[i], t6_z[i]);
      check("wrap_count_le_depth", 32'(count <= 3'd4), 32'd1);
    end
    drain();
    check("total_results", 32'(n_results), 32'd24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
